// File: rtl/mole_pkg.sv
// Shared types and constants for the mole game controller.
// Optional build macro: MOLE_SPEEDUP_EN (used by mole_scheduler).
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } state_t;

    localparam int NUM_HOLES = 16;
    localparam int IDX_W     = 4;
    localparam int LFSR_W    = 16;

    // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used as the mole position source.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;

    // Load the seed in reset, otherwise step the sequence every cycle.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game controller: schedules moles on a 4x4 grid, judges key
// presses and keeps hit/miss/escape scores.
// Optional build macro: MOLE_SPEEDUP_EN shrinks the show window every 8 hits.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int unsigned       GAP_CYCLES  = 25_000_000,
    parameter int unsigned       SHOW_CYCLES = 50_000_000,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned       SCORE_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               key_en,
    input  logic [IDX_W-1:0]   key_index,
    output logic               mole_appear,
    output logic [IDX_W-1:0]   mole_index,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] hits,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] escapes,
    output logic               running
);

    localparam int unsigned CNT_W =
        $clog2(GAP_CYCLES > SHOW_CYCLES ? GAP_CYCLES : SHOW_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               appear_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   prev_q;
    logic               hit_q;
    logic               miss_q;
    logic [SCORE_W-1:0] hits_q;
    logic [SCORE_W-1:0] misses_q;
    logic [SCORE_W-1:0] escapes_q;
    logic               running_q;

    logic [LFSR_W-1:0]  lfsr_state;
    logic [IDX_W-1:0]   pick_d;
    logic [CNT_W-1:0]   show_last;
    logic               lfsr_unused;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_state)
    );

    // Only the low nibble picks a hole; the rest of the state just feeds the sequence.
    assign lfsr_unused = ^lfsr_state[LFSR_W-1:IDX_W];

`ifdef MOLE_SPEEDUP_EN
    localparam int unsigned WIN_W     = CNT_W + 1;
    localparam int unsigned WIN_STEP  = SHOW_CYCLES / 8;
    localparam int unsigned WIN_FLOOR = SHOW_CYCLES / 4;

    logic [WIN_W-1:0] win_q;

    // The window only changes on a hit, which leaves SHOW, so a shrink is seen at the next SHOW entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= WIN_W'(SHOW_CYCLES);
        end else if (!stop && start) begin
            win_q <= WIN_W'(SHOW_CYCLES);
        end else if (!stop && state_q == SHOW && key_en && key_index == idx_q
                     && hits_q[2:0] == 3'd7 && !(&hits_q)) begin
            if (win_q >= WIN_W'(WIN_FLOOR + WIN_STEP)) begin
                win_q <= win_q - WIN_W'(WIN_STEP);
            end else begin
                win_q <= WIN_W'(WIN_FLOOR);
            end
        end
    end

    assign show_last = CNT_W'(win_q - WIN_W'(1));
`else
    assign show_last = CNT_W'(SHOW_CYCLES - 1);
`endif

    // Next hole: LFSR nibble, bumped by one if it would repeat the previous mole.
    always_comb begin
        pick_d = lfsr_state[IDX_W-1:0];
        if (lfsr_state[IDX_W-1:0] == prev_q) begin
            pick_d = lfsr_state[IDX_W-1:0] + IDX_W'(1);
        end
    end

    // Game FSM with phase counter, scores and registered outputs (stop > start > hit > timeout).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            appear_q  <= 1'b0;
            idx_q     <= '0;
            prev_q    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            hits_q    <= '0;
            misses_q  <= '0;
            escapes_q <= '0;
            running_q <= 1'b0;
        end else begin
            // NOTE: every state register uses <= so all updates see the pre-edge values.
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (stop) begin
                state_q   <= IDLE;
                appear_q  <= 1'b0;
                running_q <= 1'b0;
            end else if (start) begin
                state_q   <= GAP;
                cnt_q     <= '0;
                appear_q  <= 1'b0;
                running_q <= 1'b1;
                hits_q    <= '0;
                misses_q  <= '0;
                escapes_q <= '0;
            end else begin
                case (state_q)
                    IDLE: ;
                    GAP: begin
                        if (key_en) begin
                            misses_q <= sat_inc(misses_q);
                            miss_q   <= 1'b1;
                        end
                        if (cnt_q == GAP_LAST) begin
                            idx_q    <= pick_d;
                            prev_q   <= pick_d;
                            appear_q <= 1'b1;
                            state_q  <= SHOW;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    SHOW: begin
                        if (key_en && key_index == idx_q) begin
                            hits_q   <= sat_inc(hits_q);
                            hit_q    <= 1'b1;
                            appear_q <= 1'b0;
                            state_q  <= GAP;
                            cnt_q    <= '0;
                        end else begin
                            if (key_en) begin
                                misses_q <= sat_inc(misses_q);
                                miss_q   <= 1'b1;
                            end
                            if (cnt_q == show_last) begin
                                escapes_q <= sat_inc(escapes_q);
                                appear_q  <= 1'b0;
                                state_q   <= GAP;
                                cnt_q     <= '0;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        appear_q  <= 1'b0;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mole_appear = appear_q;
    assign mole_index  = idx_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign hits        = hits_q;
    assign misses      = misses_q;
    assign escapes     = escapes_q;
    assign running     = running_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: a cycle-level game model predicts every
// output on every edge; a separate monitor compares the DUT against it.
module tb_mole_scheduler;

    localparam int GAP_C  = 4;
    localparam int SHOW_C = 8;
    localparam int SEED   = 'hACE1;
    localparam int SMAX   = 65535;
    localparam int M_IDLE = 0;
    localparam int M_GAP  = 1;
    localparam int M_SHOW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        key_en = 1'b0;
    logic [3:0]  key_index = 4'd0;
    logic        mole_appear;
    logic [3:0]  mole_index;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [15:0] hits;
    logic [15:0] misses;
    logic [15:0] escapes;
    logic        running;

    mole_scheduler #(
        .GAP_CYCLES  (GAP_C),
        .SHOW_CYCLES (SHOW_C),
        .LFSR_SEED   (16'hACE1),
        .SCORE_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .key_en      (key_en),
        .key_index   (key_index),
        .mole_appear (mole_appear),
        .mole_index  (mole_index),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .hits        (hits),
        .misses      (misses),
        .escapes     (escapes),
        .running     (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        appear;
        logic [3:0]  idx;
        logic        hp;
        logic        mp;
        logic [15:0] hits;
        logic [15:0] misses;
        logic [15:0] escapes;
        logic        running;
        bit          was_rst;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- reference model (deadline-based game rules) ----------------
    int m_mode = M_IDLE;
    int m_edge = 0;
    int m_deadline = 0;
    int m_lfsr = SEED;
    int m_prev = 0;
    int m_idx = 0;
    int m_appear = 0;
    int m_hits = 0, m_misses = 0, m_escapes = 0;
    int m_win = SHOW_C;

    function automatic int sat(input int v);
        return (v >= SMAX) ? SMAX : v + 1;
    endfunction

    function automatic int lfsr_step(input int v);
        return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   cur;
        int   cand;
        bit   hp, mp;
        m_edge++;
        hp = 1'b0;
        mp = 1'b0;
        if (!rst) begin
            m_mode = M_IDLE; m_lfsr = SEED; m_prev = 0; m_idx = 0; m_appear = 0;
            m_hits = 0; m_misses = 0; m_escapes = 0; m_win = SHOW_C;
        end else begin
            cur = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            if (stop) begin
                m_mode = M_IDLE; m_appear = 0;
            end else if (start) begin
                m_mode = M_GAP; m_deadline = m_edge + GAP_C; m_appear = 0;
                m_hits = 0; m_misses = 0; m_escapes = 0; m_win = SHOW_C;
            end else if (m_mode == M_GAP) begin
                if (key_en) begin m_misses = sat(m_misses); mp = 1'b1; end
                if (m_edge == m_deadline) begin
                    cand = cur % 16;
                    if (cand == m_prev) cand = (cand + 1) % 16;
                    m_idx = cand; m_prev = cand; m_appear = 1;
                    m_mode = M_SHOW; m_deadline = m_edge + m_win;
                end
            end else if (m_mode == M_SHOW) begin
                if (key_en && int'(key_index) == m_idx) begin
                    m_hits = sat(m_hits); hp = 1'b1; m_appear = 0;
                    m_mode = M_GAP; m_deadline = m_edge + GAP_C;
`ifdef MOLE_SPEEDUP_EN
                    if (m_hits % 8 == 0 && m_hits != SMAX)
                        m_win = (m_win - SHOW_C / 8 < SHOW_C / 4) ? SHOW_C / 4 : m_win - SHOW_C / 8;
`endif
                end else begin
                    if (key_en) begin m_misses = sat(m_misses); mp = 1'b1; end
                    if (m_edge == m_deadline) begin
                        m_escapes = sat(m_escapes); m_appear = 0;
                        m_mode = M_GAP; m_deadline = m_edge + GAP_C;
                    end
                end
            end
        end
        e.appear = 1'(m_appear); e.idx = 4'(m_idx); e.hp = hp; e.mp = mp;
        e.hits = 16'(m_hits); e.misses = 16'(m_misses); e.escapes = 16'(m_escapes);
        e.running = (m_mode != M_IDLE); e.was_rst = !rst;
        sb.push_back(e);
    end

    // ---------------- monitor ----------------
    logic       last_appear = 1'b0;
    logic [3:0] last_idx = 4'd0;

    always @(posedge clk) begin
        exp_t e;
        bit   ok;
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1'b0, "no expected entry for this edge");
        end else begin
            e = sb.pop_front();
            ok = (mole_appear === e.appear) && (mole_index === e.idx) &&
                 (hit_pulse === e.hp) && (miss_pulse === e.mp) &&
                 (hits === e.hits) && (misses === e.misses) &&
                 (escapes === e.escapes) && (running === e.running);
            check("outputs", ok, $sformatf(
                "t=%0t got app=%b idx=%0d hp=%b mp=%b h=%0d m=%0d e=%0d run=%b, want app=%b idx=%0d hp=%b mp=%b h=%0d m=%0d e=%0d run=%b",
                $time, mole_appear, mole_index, hit_pulse, miss_pulse, hits, misses, escapes, running,
                e.appear, e.idx, e.hp, e.mp, e.hits, e.misses, e.escapes, e.running));
            if (e.was_rst) begin
                last_idx = 4'd0;
            end else if (mole_appear === 1'b1 && last_appear !== 1'b1) begin
                check("index_repeat", mole_index !== last_idx,
                      $sformatf("new mole at %0d, previous mole also %0d", mole_index, last_idx));
                last_idx = mole_index;
            end
            last_appear = mole_appear;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit s, input bit p, input bit k, input int ki);
        start = s; stop = p; key_en = k; key_index = 4'(ki);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; key_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic wait_show();
        int budget = 100;
        while (m_mode != M_SHOW && budget > 0) begin idle(1); budget--; end
        if (m_mode != M_SHOW) check("wait_show", 1'b0, $sformatf("model mode %0d, want SHOW", m_mode));
    endtask

    task automatic wait_gap();
        int budget = 100;
        while (m_mode != M_GAP && budget > 0) begin idle(1); budget--; end
        if (m_mode != M_GAP) check("wait_gap", 1'b0, $sformatf("model mode %0d, want GAP", m_mode));
    endtask

    initial begin
        @(negedge clk);
        // Reset held for three edges, then idle with stray keys.
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, (i % 3) == 0, i);
        // Start; let the first mole escape untouched.
        cyc(1'b1, 1'b0, 1'b0, 0);
        idle(GAP_C + SHOW_C + 2);
        // Correct hit.
        wait_show();
        cyc(1'b0, 1'b0, 1'b1, m_idx);
        // Wrong key in SHOW, then a key in GAP.
        wait_show();
        cyc(1'b0, 1'b0, 1'b1, m_idx ^ 1);
        wait_gap();
        cyc(1'b0, 1'b0, 1'b1, 5);
        // Correct key exactly on the timeout edge.
        begin
            int budget = 100;
            while (!(m_mode == M_SHOW && m_edge + 1 == m_deadline) && budget > 0) begin
                idle(1); budget--;
            end
            check("wait_timeout_edge", m_mode == M_SHOW && m_edge + 1 == m_deadline,
                  "could not reach the timeout cycle");
            cyc(1'b0, 1'b0, 1'b1, m_idx);
        end
        // start and stop together while running; then restart mid-SHOW.
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 0);
        wait_show();
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 0);
        // Stop mid-SHOW, then reset mid-SHOW.
        wait_show();
        cyc(1'b0, 1'b1, 1'b0, 0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 0);
        wait_show();
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(5);
        // Long run of quick hits (exercises window shrink when enabled), then an escape.
        cyc(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 56; i++) begin
            wait_show();
            cyc(1'b0, 1'b0, 1'b1, m_idx);
        end
        idle(GAP_C + SHOW_C + 4);
        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            bit s, p, k;
            int ki;
            s = ($urandom_range(0, 199) == 0);
            p = ($urandom_range(0, 299) == 0);
            k = ($urandom_range(0, 3) == 0);
            ki = (m_mode == M_SHOW && $urandom_range(0, 1) == 1) ? m_idx : int'($urandom_range(0, 15));
            if (m_mode == M_IDLE && $urandom_range(0, 19) == 0) s = 1'b1;
            if ($urandom_range(0, 999) == 0) rst = 1'b0;
            cyc(s, p, k, ki);
            rst = 1'b1;
        end
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Game-control producer for the 4x4 mole grid renderer.
- Generates the `mole_appear` / `mole_index` pair that the renderer consumes, and judges the `key_en` / `key_index` hits from the keypad against the active mole.
- Keeps hit, miss and escape counts for the score display.
- Sits between the keypad scanner and the mole renderer, in the pixel-clock domain.

Parameters:
- GAP_CYCLES, 25_000_000, cycles with no mole shown between appearances (min 2).
- SHOW_CYCLES, 50_000_000, cycles a mole stays up before escaping (min 8).
- LFSR_SEED, 16'hACE1, nonzero reset value of the index LFSR.
- SCORE_W, 16, width of the hit/miss/escape counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse: clear counters and begin a game.
- stop  in  1  one-cycle pulse: end the game, return to IDLE.
- key_en  in  1  one-cycle pulse: a key was pressed.
- key_index  in  4  hole pressed, 0..15, row-major.
- mole_appear  out  1  high while a mole is up.
- mole_index  out  4  hole of the current mole; held stable while `mole_appear` is high.
- hit_pulse  out  1  one-cycle pulse on a correct hit.
- miss_pulse  out  1  one-cycle pulse on a wrong-hole or no-mole key.
- hits  out  SCORE_W  correct hits this game.
- misses  out  SCORE_W  wrong keys this game.
- escapes  out  SCORE_W  moles that timed out this game.
- running  out  1  high in the GAP and SHOW states.

Behaviour:
- Reset (`rst`=0 at an edge):
  - state goes to IDLE; the LFSR loads LFSR_SEED.
  - All outputs go to 0; the previous-index register goes to 0.
- All outputs are registered. Every response below appears one cycle after the triggering input edge.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state except reset.
- States:
  - IDLE:
    - `mole_appear`=0, `running`=0.
    - `start` → GAP, with the phase counter at 0 and `hits`/`misses`/`escapes` at 0.
    - `key_en` is ignored (no `miss_pulse`).
  - GAP:
    - The phase counter counts up. When it reaches GAP_CYCLES-1: candidate = LFSR[3:0].
    - If candidate equals the previous index, use (candidate+1) mod 16 instead.
    - Latch the result into `mole_index` and the previous-index register, raise `mole_appear`, go to SHOW, and clear the counter.
    - `key_en` in GAP: `misses`+1, `miss_pulse`.
  - SHOW:
    - `key_en` with `key_index`==`mole_index`: `hits`+1, `hit_pulse`, `mole_appear`→0, go to GAP, clear the counter.
    - `key_en` with another index: `misses`+1, `miss_pulse`; stay in SHOW, counter keeps running.
    - Counter reaches SHOW_CYCLES-1 with no hit that cycle: `escapes`+1, `mole_appear`→0, go to GAP.
- Priority:
  - `stop` > `start` > hit > timeout.
  - A hit in the same cycle as the timeout counts as a hit only.
  - `start` while running restarts: counters cleared, go to GAP. `mole_appear`→0 if it was up; no escape counted.
  - `stop` from any state → IDLE with `mole_appear`→0. Counters hold their values for display.
- Counter arithmetic: all counters saturate at all-ones; no wrap.
- Pulses: `hit_pulse` and `miss_pulse` are exactly one cycle and mutually exclusive.
- Reset mid-SHOW: `mole_appear` drops on the same edge; the next game starts only on `start`.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- When defined:
  - The effective show window starts at SHOW_CYCLES.
  - After every 8th hit it shrinks by SHOW_CYCLES/8, with a floor of SHOW_CYCLES/4.
  - `start` restores the full window.
  - The shrink takes effect from the next SHOW entry.
- When undefined: the window is always SHOW_CYCLES and no extra registers exist.

Decomposition:
- Package `mole_pkg`:
  - state enum {IDLE, GAP, SHOW}.
  - NUM_HOLES=16, IDX_W=4.
  - LFSR tap mask constant.
- Sub-module `mole_lfsr`: seed parameter, `clk`/`rst`, 16-bit state output. Instantiated once.
- The FSM and counters stay in `mole_scheduler`.

Test Plan:
All scenarios use GAP_CYCLES=4 and SHOW_CYCLES=8.
- Reset: hold `rst`=0 for 3 cycles, release, no start → all outputs 0 for 20 cycles.
- Appearance timing: `start` pulse → `running`=1 next cycle; `mole_appear` rises 4 cycles after entering GAP. With no keys, it falls after 8 cycles and `escapes`=1. `mole_index` is never equal on two consecutive appearances over 64 appearances.
- Hit: in SHOW, `key_en`=1 with `key_index`=`mole_index` → `hit_pulse` for 1 cycle, `hits`=1, `mole_appear`=0 next cycle, `escapes` unchanged.
- Wrong keys: in SHOW, `key_en` with `key_index`=`mole_index`^1 → `miss_pulse`, `misses`=1, `mole_appear` stays 1. A `key_en` in GAP also gives `misses`+1. A `key_en` in IDLE gives no change.
- Same-cycle collision: a correct `key_en` on the timeout cycle → `hits`+1 and `escapes` unchanged. `start` and `stop` asserted together → IDLE.
- MOLE_SPEEDUP_EN: after 8 hits the SHOW window is 7 cycles; after 48 hits it stays at 2 cycles.
